// File: rtl/dfh_chain_walker.sv
// Walks a DFH linked list via 64-bit CSR reads and emits one record per header found.
// Latency: 1 cycle start->request, 1 cycle response->record, 1 cycle record accept->next request.
module dfh_chain_walker #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  START_OFFSET = '0,
    parameter int                 MAX_DFH      = 16,
    parameter logic [ADDR_W-1:0]  ADDR_LIMIT   = ADDR_W'(32'h0008_0000),
    parameter int                 TIMEOUT_CYC  = 1024,
    localparam int                IDX_W        = $clog2(MAX_DFH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [63:0]       rd_rsp_data,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [IDX_W-1:0]  rec_idx,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [63:0]       rec_dfh,
    output logic              rec_last,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err_code,
    output logic [IDX_W-1:0]  dfh_count
);

    localparam int             TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TMO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [TO_W-1:0]   tmo_cnt;
    logic [2:0]        err_nxt;
    logic [IDX_W-1:0]  cnt_inc;
    logic [ADDR_W:0]   next_sum;
    logic              addr_bad;

    // One extra bit so a wrap past the top of the address space is visible.
    assign next_sum = {1'b0, cur_addr} + (ADDR_W+1)'(rec_dfh[39:16]);
    assign addr_bad = next_sum[ADDR_W] || (next_sum[ADDR_W-1:0] >= ADDR_LIMIT);
    assign cnt_inc  = dfh_count + IDX_W'(1);

    assign rd_req_valid = (state == S_REQ);
    assign rd_req_addr  = cur_addr;
    assign rec_valid    = (state == S_EMIT);
    assign rec_last     = rec_dfh[40];
    assign busy         = (state == S_REQ) || (state == S_WAIT) || (state == S_EMIT);
    assign done         = (state == S_FIN);

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_REQ;
                    err_nxt   = 3'd0;
                end
            end
            S_REQ: begin
                if (rd_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rd_rsp_valid) begin
                    state_nxt = S_EMIT;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_FIN;
                    err_nxt   = 3'd1;
                end
            end
            S_EMIT: begin
                if (rec_ready) begin
                    state_nxt = S_FIN;
                    if (rec_dfh[40]) begin
                        err_nxt = 3'd0;
                    end else if (rec_dfh[39:16] == 24'd0) begin
                        err_nxt = 3'd2;
                    end else if (cnt_inc == IDX_W'(MAX_DFH)) begin
                        err_nxt = 3'd3;
                    end else if (addr_bad) begin
                        err_nxt = 3'd4;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_addr  <= START_OFFSET;
            tmo_cnt   <= '0;
            err_code  <= 3'd0;
            dfh_count <= '0;
            rec_idx   <= '0;
            rec_addr  <= '0;
            rec_dfh   <= '0;
        end else begin
            state    <= state_nxt;
            err_code <= err_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dfh_count <= '0;
                        cur_addr  <= START_OFFSET;
                    end
                end
                S_REQ: begin
                    if (rd_req_ready) tmo_cnt <= '0;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TO_W'(1);
                    if (rd_rsp_valid) begin
                        rec_dfh  <= rd_rsp_data;
                        rec_addr <= cur_addr;
                        rec_idx  <= dfh_count;
                    end
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        dfh_count <= cnt_inc;
                        if (state_nxt == S_REQ) cur_addr <= next_sum[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dfh_chain_walker.sv
// Scoreboarded bench for dfh_chain_walker: memory responder, stall injection and error walks.
module tb_dfh_chain_walker;
    localparam int ADDR_W  = 32;
    localparam int MAX_DFH = 4;
    localparam int TMO     = 1024;
    localparam int IDX_W   = $clog2(MAX_DFH + 1);

    logic              clk = 1'b0;
    logic              rst, start, rd_req_ready, rd_rsp_valid, rec_ready;
    logic [63:0]       rd_rsp_data;
    logic              rd_req_valid, rec_valid, rec_last, busy, done;
    logic [ADDR_W-1:0] rd_req_addr, rec_addr;
    logic [IDX_W-1:0]  rec_idx, dfh_count;
    logic [63:0]       rec_dfh;
    logic [2:0]        err_code;

    dfh_chain_walker #(.MAX_DFH(MAX_DFH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_idx(rec_idx), .rec_addr(rec_addr),
        .rec_dfh(rec_dfh), .rec_last(rec_last), .busy(busy), .done(done),
        .err_code(err_code), .dfh_count(dfh_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       dfh;
        logic              last;
    } rec_t;
    typedef struct {
        int          due;
        logic [63:0] dat;
    } rsp_t;

    rec_t        exp_q[$];
    rsp_t        rsp_q[$];
    logic [63:0] mem [logic [31:0]];

    int cyc = 0, rsp_lat = 2, req_stall = 0, rec_stall = 0, drop_req = -1;
    int req_cnt = 0, hs_cyc = 0, req_wait = 0, rec_wait = 0;
    bit hold_v = 1'b0;
    logic [IDX_W-1:0]  held_idx;
    logic [ADDR_W-1:0] held_addr;
    logic [63:0]       held_dfh;

    function automatic logic [63:0] mk(input logic [3:0] ft, input logic eol,
                                       input logic [23:0] nxt, input logic [15:0] id);
        return {ft, 19'd0, eol, nxt, id};
    endfunction

    task automatic push_exp(input int idx, input logic [31:0] addr, input logic [63:0] dfh, input logic last);
        rec_t r;
        r.idx = IDX_W'(idx); r.addr = addr; r.dfh = dfh; r.last = last;
        exp_q.push_back(r);
    endtask

    // Memory responder, stall injection and record scoreboard, all driven on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (hold_v && rec_valid) begin
            check("stall_idx", rec_idx, held_idx);
            check("stall_addr", rec_addr, held_addr);
            check("stall_dfh", rec_dfh, held_dfh);
        end
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = rsp_q[0].dat;
            void'(rsp_q.pop_front());
        end
        if (rd_req_valid) begin
            if (req_wait < req_stall) begin rd_req_ready = 1'b0; req_wait++; end
            else rd_req_ready = 1'b1;
        end else begin
            rd_req_ready = 1'b0;
            req_wait = 0;
        end
        if (rd_req_valid && rd_req_ready) begin
            if (req_cnt != drop_req) begin
                rsp_t r;
                r.due = cyc + rsp_lat;
                r.dat = mem.exists(rd_req_addr) ? mem[rd_req_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
                rsp_q.push_back(r);
            end
            req_cnt++;
            hs_cyc = cyc + 1;
            req_wait = 0;
        end
        if (rec_valid) begin
            if (rec_wait < rec_stall) begin rec_ready = 1'b0; rec_wait++; end
            else rec_ready = 1'b1;
        end else begin
            rec_ready = 1'b0;
            rec_wait = 0;
        end
        if (rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                check("rec_extra", 1, 0);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                check("rec_idx", rec_idx, e.idx);
                check("rec_addr", rec_addr, e.addr);
                check("rec_dfh", rec_dfh, e.dfh);
                check("rec_last", rec_last, e.last);
            end
            rec_wait = 0;
        end
        hold_v    = rec_valid && !rec_ready;
        held_idx  = rec_idx;
        held_addr = rec_addr;
        held_dfh  = rec_dfh;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_walk(input string nm, input int exp_err, input int exp_cnt,
                            input int exp_reads, output int done_at);
        bit seen;
        int r0;
        r0 = req_cnt;
        seen = 1'b0;
        done_at = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, "_busy_go"}, busy, 1);
        check({nm, "_req_go"}, rd_req_valid, 1);
        for (int n = 0; n < 5000 && !seen; n++) begin
            tick();
            if (done) begin seen = 1'b1; done_at = cyc; end
        end
        check({nm, "_done"}, seen, 1);
        if (seen) begin
            check({nm, "_busy_fin"}, busy, 0);
            check({nm, "_err"}, err_code, exp_err);
            check({nm, "_cnt"}, dfh_count, exp_cnt);
            check({nm, "_reads"}, req_cnt - r0, exp_reads);
            check({nm, "_q_empty"}, exp_q.size(), 0);
            tick();
            check({nm, "_done_1cyc"}, done, 0);
            check({nm, "_err_hold"}, err_code, exp_err);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic load_chain();
        mem.delete();
        mem[32'h0]    = mk(4'h3, 1'b0, 24'h1000, 16'h0a0);
        mem[32'h1000] = mk(4'h2, 1'b0, 24'h2000, 16'h0a1);
        mem[32'h3000] = mk(4'h4, 1'b1, 24'h0,    16'h0a2);
    endtask

    task automatic push_chain();
        push_exp(0, 32'h0,    mk(4'h3, 1'b0, 24'h1000, 16'h0a0), 1'b0);
        push_exp(1, 32'h1000, mk(4'h2, 1'b0, 24'h2000, 16'h0a1), 1'b0);
        push_exp(2, 32'h3000, mk(4'h4, 1'b1, 24'h0,    16'h0a2), 1'b1);
    endtask

    initial begin
        int d;
        int r0;
        int ndone, nrec;
        rst = 1'b1; start = 1'b0;
        rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0; rec_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req_v", rd_req_valid, 0);
        check("rst_rec_v", rec_valid, 0);
        check("rst_err", err_code, 0);
        check("rst_cnt", dfh_count, 0);
        check("rst_rec_dfh", rec_dfh, 0);
        check("rst_rec_addr", rec_addr, 0);

        load_chain(); push_chain();
        run_walk("chain", 0, 3, 3, d);

        req_stall = 3; rec_stall = 5;
        load_chain(); push_chain();
        run_walk("stall", 0, 3, 3, d);
        req_stall = 0; rec_stall = 0;

        load_chain();
        drop_req = req_cnt + 1;
        push_exp(0, 32'h0, mk(4'h3, 1'b0, 24'h1000, 16'h0a0), 1'b0);
        run_walk("tmo", 1, 1, 2, d);
        check("tmo_cycles", d - hs_cyc, TMO);
        drop_req = -1;

        mem.delete();
        mem[32'h0]    = mk(4'h1, 1'b0, 24'h1000, 16'h0b0);
        mem[32'h1000] = mk(4'h1, 1'b0, 24'h0,    16'h0b1);
        push_exp(0, 32'h0,    mk(4'h1, 1'b0, 24'h1000, 16'h0b0), 1'b0);
        push_exp(1, 32'h1000, mk(4'h1, 1'b0, 24'h0,    16'h0b1), 1'b0);
        run_walk("nxt0", 2, 2, 2, d);

        mem.delete();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = 32'(i) * 32'h100;
            mem[a] = mk(4'h5, 1'b0, 24'h100, 16'(i));
            if (i < MAX_DFH) push_exp(i, a, mk(4'h5, 1'b0, 24'h100, 16'(i)), 1'b0);
        end
        run_walk("max", 3, MAX_DFH, MAX_DFH, d);

        mem.delete();
        mem[32'h0]    = mk(4'h1, 1'b0, 24'h1000,  16'h0c0);
        mem[32'h1000] = mk(4'h1, 1'b0, 24'h7F000, 16'h0c1);
        push_exp(0, 32'h0,    mk(4'h1, 1'b0, 24'h1000,  16'h0c0), 1'b0);
        push_exp(1, 32'h1000, mk(4'h1, 1'b0, 24'h7F000, 16'h0c1), 1'b0);
        run_walk("limit", 4, 2, 2, d);

        // Reset while a read is outstanding; its late response must be dropped.
        load_chain();
        rsp_lat = 6;
        r0 = req_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 50 && req_cnt == r0; n++) tick();
        check("rstw_req_seen", req_cnt - r0, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_busy", busy, 0);
        check("rstw_req_v", rd_req_valid, 0);
        check("rstw_err", err_code, 0);
        check("rstw_cnt", dfh_count, 0);
        ndone = 0; nrec = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done) ndone++;
            if (rec_valid) nrec++;
        end
        check("rstw_no_done", ndone, 0);
        check("rstw_no_rec", nrec, 0);
        check("rstw_rsp_drained", rsp_q.size(), 0);
        rsp_lat = 2;
        load_chain(); push_chain();
        run_walk("rewalk", 0, 3, 3, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/dfh_chain_walker.md
Name: dfh_chain_walker

Overview:
- Hardware DFH list walker. Starts at a base CSR offset and issues 64-bit CSR reads. Follows each header's next-offset field until it finds EOL.
- Emits one record per header found: index, byte address and raw 64-bit DFH.
- Feeds the DFH checker stage, which compares each record's name and index against the expected per-index DFH value table.
- Sits between the host-side CSR read path (BAR 0) and that checker, in the dfh_walker unit bench and the FIM self-test path.

Parameters:
- ADDR_W, 32, CSR byte-address width.
- START_OFFSET, 32'h0, address of the first DFH.
- MAX_DFH, 16, maximum headers walked before an overflow error; the index width is $clog2(MAX_DFH+1).
- ADDR_LIMIT, 32'h0008_0000, exclusive upper bound of a legal DFH address.
- TIMEOUT_CYC, 1024, read-response timeout in cycles.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a walk when idle.
- rd_req_valid  out  1  CSR read request.
- rd_req_ready  in  1  request accepted.
- rd_req_addr  out  ADDR_W  byte address, 8-byte aligned.
- rd_rsp_valid  in  1  read data valid.
- rd_rsp_data  in  64  read data.
- rec_valid  out  1  DFH record valid.
- rec_ready  in  1  checker accepts the record.
- rec_idx  out  IDX_W  ordinal of the header, 0-based.
- rec_addr  out  ADDR_W  address the header was read from.
- rec_dfh  out  64  raw DFH word.
- rec_last  out  1  record has EOL set.
- busy  out  1  walk in progress.
- done  out  1  one-cycle pulse when a walk ends, normally or on error.
- err_code  out  3  sticky until the next accepted start: 0 none, 1 timeout, 2 zero next offset without EOL, 3 MAX_DFH exceeded, 4 address at or above ADDR_LIMIT or wrapped.
- dfh_count  out  IDX_W  number of records accepted in the last or current walk.

Behaviour:
- Reset state: state IDLE; all valids, busy, done = 0; err_code, dfh_count, rec_* = 0; address register = START_OFFSET.

- DFH fields used:
  - eol = dfh[40]
  - nxt = dfh[39:16], 24-bit unsigned byte offset
  - feat_type = dfh[63:60], carried only

- State IDLE:
  - start=1 → clear err_code and dfh_count, cur_addr = START_OFFSET, busy=1, go to REQ.
  - start while busy is ignored.

- State REQ:
  - rd_req_valid=1 with rd_req_addr=cur_addr. Address and valid stay stable until rd_req_ready.
  - Handshake → WAIT, timeout counter = 0.

- State WAIT:
  - Counter increments each cycle.
  - rd_rsp_valid → capture the data, go to EMIT.
  - Counter reaches TIMEOUT_CYC-1 without a response → err_code=1, go to FIN. No record is emitted.
  - rd_rsp_valid is ignored in every state other than WAIT.

- State EMIT:
  - rec_valid=1. rec_* are registered and held stable until rec_ready; no timeout on rec_ready.
  - rec_last = eol. On the handshake dfh_count increments, then the checks below run in priority order:
    1. eol → FIN, err 0.
    2. nxt==0 → err 2, FIN.
    3. dfh_count (post-increment) == MAX_DFH → err 3, FIN.
    4. next = cur_addr + nxt, computed with ADDR_W+1 bits. Carry out, or next ≥ ADDR_LIMIT → err 4, FIN.
    5. Otherwise cur_addr = next, go to REQ.

- State FIN:
  - done=1 for exactly one cycle, busy=0, go to IDLE.
  - err_code and dfh_count hold.

- Latency:
  - start to first rd_req_valid: 1 cycle.
  - rd_rsp_valid to rec_valid: 1 cycle.
  - rec handshake to the next rd_req_valid: 1 cycle.
  - Best case is 3 cycles per header plus the read latency.

- Unaligned nxt (low 3 bits ≠ 0) is followed as is; the checker flags it.

- rst mid-walk:
  - Returns to IDLE in the next cycle; outputs return to reset values, no done pulse.
  - An in-flight response arriving after rst is ignored.

- start in the same cycle as done: ignored. start must arrive on a cycle where busy=0 and done=0.

Test Plan:
- Chain 0x0 (nxt 0x1000), 0x1000 (nxt 0x2000), 0x3000 (eol=1). Memory returns data 2 cycles after each request → three records, idx 0/1/2, addr 0x0/0x1000/0x3000; rec_last only on idx 2; done pulse; err_code 0; dfh_count 3.
- Same chain with rec_ready held low 5 cycles per record and rd_req_ready low 3 cycles → identical record sequence, rec_* stable while stalled, no extra reads issued.
- No response to the second request → done exactly TIMEOUT_CYC cycles after the request handshake; err_code 1; dfh_count 1.
- Header at 0x1000 with nxt=0 and eol=0 → record idx 1 emitted, then err_code 2, dfh_count 2.
- MAX_DFH=4 with an 8-entry loop of nxt=0x100 → 4 records, err_code 3. Separately, nxt=0x7F000 from 0x1000 → err_code 4.
- Assert rst while in WAIT → busy 0 next cycle, no done; late rd_rsp_valid ignored. A new start re-walks from START_OFFSET correctly.
